mem_arbiter: RTL and testbench

//  Shares the single main-memory port between the instruction cache and the data cache.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_picker.sv | 56 +++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the icache/dcache main-memory arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_LINE_BITS    = 128;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

    // A writeback wins if the dcache ever raises read and write together.
    function automatic mem_op_t dc_op_of(input logic req_write);
        return req_write ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Grant decision for an idle arbiter plus the dcache streak counter that
// forces an icache grant once instruction fetch has waited long enough.
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic flush,
    input  logic ic_req,
    input  logic ic_done,
    input  logic dc_req,
    input  logic dc_done,
    output logic grant_i,
    output logic grant_d
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak;
    logic ic_pend;
    logic dc_pend;
    logic starved;

    // A requester whose done is showing this cycle is already served.
    always_comb begin
        ic_pend = ic_req && !ic_done && !flush;
        dc_pend = dc_req && !dc_done;
        starved = (streak == STREAK_MAX);
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (arb_en) begin
            if (dc_pend && ic_pend && starved) begin
                grant_i = 1'b1;
            end else if (dc_pend) begin
                grant_d = 1'b1;
            end else if (ic_pend) begin
                grant_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (!ic_req || grant_i) begin
            streak <= '0;
        end else if (grant_d && streak != STREAK_MAX) begin
            streak <= streak + STREAK_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between icache and dcache: one command
// at a time, held until mem_ready, then a one-cycle done pulse to the owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_BITS    = DEFAULT_LINE_BITS,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 ic_req,
    input  logic [31:0]          ic_addr,
    output logic [LINE_BITS-1:0] ic_rdata,
    output logic                 ic_done,
    input  logic                 dc_req_read,
    input  logic                 dc_req_write,
    input  logic [31:0]          dc_addr,
    input  logic [LINE_BITS-1:0] dc_wdata,
    output logic [LINE_BITS-1:0] dc_rdata,
    output logic                 dc_done,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          address,
    output logic [LINE_BITS-1:0] writedata,
    input  logic [LINE_BITS-1:0] mem_readdata,
    input  logic                 mem_ready,
    output logic                 requested_data_to_mem
);

    arb_state_t state;
    mem_op_t    op;
    logic       ic_cancel;
    logic       grant_i;
    logic       grant_d;

    mem_arb_picker #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_picker (
        .clk     (clk),
        .reset   (reset),
        .arb_en  (state == IDLE),
        .flush   (flush),
        .ic_req  (ic_req),
        .ic_done (ic_done),
        .dc_req  (dc_req_read || dc_req_write),
        .dc_done (dc_done),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign requested_data_to_mem = (state != IDLE);

    // ic_cancel remembers a flush seen at any point of an icache fetch so the
    // memory side still completes while the stale line is never reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op        <= OP_READ;
            ic_cancel <= 1'b0;
            ic_rdata  <= '0;
            ic_done   <= 1'b0;
            dc_rdata  <= '0;
            dc_done   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            address   <= '0;
            writedata <= '0;
        end else begin
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= GRANT_D;
                        op        <= dc_op_of(dc_req_write);
                        address   <= dc_addr;
                        writedata <= dc_wdata;
                        mem_read  <= !dc_req_write;
                        mem_write <= dc_req_write;
                    end else if (grant_i) begin
                        state     <= GRANT_I;
                        op        <= OP_READ;
                        address   <= ic_addr;
                        writedata <= '0;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
                        ic_cancel <= 1'b0;
                    end
                end
                GRANT_I: begin
                    if (flush) begin
                        ic_cancel <= 1'b1;
                    end
                    if (mem_ready) begin
                        state    <= RESP;
                        mem_read <= 1'b0;
                        ic_rdata <= mem_readdata;
                        ic_done  <= !(ic_cancel || flush);
                    end
                end
                GRANT_D: begin
                    if (mem_ready) begin
                        state     <= RESP;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        dc_done   <= 1'b1;
                        if (op == OP_READ) begin
                            dc_rdata <= mem_readdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter with a variable-latency memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LB = 128;

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [LB-1:0] data;
        int            cyc;
    } cmd_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          ic_req;
    logic [31:0]   ic_addr;
    logic [LB-1:0] ic_rdata;
    logic          ic_done;
    logic          dc_req_read;
    logic          dc_req_write;
    logic [31:0]   dc_addr;
    logic [LB-1:0] dc_wdata;
    logic [LB-1:0] dc_rdata;
    logic          dc_done;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   address;
    logic [LB-1:0] writedata;
    logic [LB-1:0] mem_readdata = '0;
    logic          mem_ready = 1'b0;
    logic          requested_data_to_mem;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mem_latency = 0;
    int   lat_cnt = 0;
    int   mem_acks = 0;
    int   ic_pulses = 0;
    int   ic_high = 0;
    int   dc_pulses = 0;
    int   log_rd = 0;
    logic cmd_now = 1'b0;
    logic cmd_prev = 1'b0;
    logic ic_prev = 1'b0;
    logic dc_prev = 1'b0;
    cmd_t mon_c;
    cmd_t cmd_log[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk                   (clk),
        .reset                 (reset),
        .flush                 (flush),
        .ic_req                (ic_req),
        .ic_addr               (ic_addr),
        .ic_rdata              (ic_rdata),
        .ic_done               (ic_done),
        .dc_req_read           (dc_req_read),
        .dc_req_write          (dc_req_write),
        .dc_addr               (dc_addr),
        .dc_wdata              (dc_wdata),
        .dc_rdata              (dc_rdata),
        .dc_done               (dc_done),
        .mem_read              (mem_read),
        .mem_write             (mem_write),
        .address               (address),
        .writedata             (writedata),
        .mem_readdata          (mem_readdata),
        .mem_ready             (mem_ready),
        .requested_data_to_mem (requested_data_to_mem)
    );

    function automatic logic [LB-1:0] line_of(input logic [31:0] a);
        return {a, ~a, a ^ 32'h1234_5678, a + 32'h0BAD_F00D};
    endfunction

    function automatic exp_t exp_cmd(input logic wr, input logic [31:0] a);
        exp_t e;
        e.wr   = wr;
        e.addr = a;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Command/done monitor and memory model; mem_ready rises mem_latency
    // cycles after the command first appears and drops once it is consumed.
    always @(negedge clk) begin
        if (reset) begin
            mem_ready = 1'b0;
            lat_cnt   = 0;
            cmd_prev  = 1'b0;
            ic_prev   = 1'b0;
            dc_prev   = 1'b0;
        end else begin
            cmd_now = mem_read | mem_write;
            if (cmd_now && !cmd_prev) begin
                mon_c.wr   = mem_write;
                mon_c.addr = address;
                mon_c.data = writedata;
                mon_c.cyc  = cyc;
                cmd_log.push_back(mon_c);
            end
            cmd_prev = cmd_now;
            if (ic_done) begin
                ic_high++;
                if (!ic_prev) ic_pulses++;
            end
            ic_prev = ic_done;
            if (dc_done && !dc_prev) dc_pulses++;
            dc_prev = dc_done;
            if (cmd_now && !mem_ready) begin
                if (lat_cnt >= mem_latency) begin
                    mem_ready    = 1'b1;
                    mem_readdata = line_of(address);
                    lat_cnt      = 0;
                    mem_acks++;
                end else begin
                    lat_cnt++;
                    mem_readdata = ~line_of(address);
                end
            end else begin
                mem_ready    = 1'b0;
                mem_readdata = ~line_of(address);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cmd(output cmd_t c, output bit ok);
        ok = (log_rd < cmd_log.size());
        if (ok) begin
            c = cmd_log[log_rd];
            log_rd++;
        end else begin
            c.wr = 1'bx;
            c.addr = 'x;
            c.data = 'x;
            c.cyc = -1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({mem_read, mem_write, ic_done, dc_done, requested_data_to_mem} !== 5'b0) begin
                failures++;
                $display("[TB] FAIL reset_ctrl cycle=%0d got=%b want=00000", i,
                         {mem_read, mem_write, ic_done, dc_done, requested_data_to_mem});
            end
            checks++;
            if ((address !== 32'h0) || (writedata !== '0) || (ic_rdata !== '0) || (dc_rdata !== '0)) begin
                failures++;
                $display("[TB] FAIL reset_bus cycle=%0d addr=%h wdata=%h ic=%h dc=%h want all 0",
                         i, address, writedata, ic_rdata, dc_rdata);
            end
        end
        reset       = 1'b0;
        ic_req      = 1'b0;
        dc_req_read = 1'b0;
        repeat (2) tick();
        checks++;
        if (cmd_log.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_no_cmd got=%0d commands want=0", cmd_log.size());
        end
    endtask

    task automatic test_lone_ic();
        int   n;
        int   ic0;
        bit   seen;
        bit   ok;
        exp_t e;
        cmd_t c;
        mem_latency = 3;
        ic0 = ic_pulses;
        ic_addr = 32'h40;
        ic_req  = 1'b1;
        exp_q.push_back(exp_cmd(1'b0, 32'h40));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            tick();
            n++;
            if (ic_done) seen = 1'b1;
        end
        ic_req = 1'b0;
        checks++;
        if (!seen || n != 5) begin
            failures++;
            $display("[TB] FAIL lone_ic_latency got=%0d seen=%0b want=5", n, seen);
        end
        checks++;
        if (ic_rdata !== line_of(32'h40)) begin
            failures++;
            $display("[TB] FAIL lone_ic_rdata got=%h want=%h", ic_rdata, line_of(32'h40));
        end
        repeat (3) tick();
        checks++;
        if ((ic_pulses - ic0) != 1 || ic_high != ic_pulses) begin
            failures++;
            $display("[TB] FAIL lone_ic_pulse got pulses=%0d high=%0d want 1 single-cycle pulse",
                     ic_pulses - ic0, ic_high);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_cmd(c, ok);
            checks++;
            if (!ok || c.wr !== e.wr || c.addr !== e.addr) begin
                failures++;
                $display("[TB] FAIL lone_ic_cmd got wr=%b addr=%h want wr=%b addr=%h", c.wr, c.addr, e.wr, e.addr);
            end
        end
    endtask

    task automatic test_simultaneous();
        int   n;
        bit   ic_seen;
        bit   dc_seen;
        bit   ok;
        exp_t e;
        cmd_t c;
        mem_latency = 1;
        ic_addr = 32'h100;
        dc_addr = 32'h200;
        ic_req      = 1'b1;
        dc_req_read = 1'b1;
        exp_q.push_back(exp_cmd(1'b0, 32'h200));
        exp_q.push_back(exp_cmd(1'b0, 32'h100));
        n = 0;
        ic_seen = 1'b0;
        dc_seen = 1'b0;
        while (!(ic_seen && dc_seen) && n < 40) begin
            tick();
            n++;
            if (dc_done) begin
                dc_seen = 1'b1;
                dc_req_read = 1'b0;
                checks++;
                if (dc_rdata !== line_of(32'h200)) begin
                    failures++;
                    $display("[TB] FAIL simul_dc_rdata got=%h want=%h", dc_rdata, line_of(32'h200));
                end
            end
            if (ic_done) begin
                ic_seen = 1'b1;
                ic_req = 1'b0;
            end
        end
        checks++;
        if (!(ic_seen && dc_seen) || ic_rdata !== line_of(32'h100)) begin
            failures++;
            $display("[TB] FAIL simul_ic_done seen=%b%b ic_rdata=%h want=%h", ic_seen, dc_seen,
                     ic_rdata, line_of(32'h100));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_cmd(c, ok);
            checks++;
            if (!ok || c.wr !== e.wr || c.addr !== e.addr) begin
                failures++;
                $display("[TB] FAIL simul_order got addr=%h want addr=%h", c.addr, e.addr);
            end
        end
    endtask

    task automatic test_starvation();
        int   n;
        int   k;
        int   ic_seen;
        int   first;
        bit   ok;
        exp_t e;
        cmd_t c;
        mem_latency = 0;
        first = cmd_log.size();
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                exp_q.push_back(exp_cmd(1'b0, 32'h300 + 32'(16 * (4 * r + d))));
            end
            exp_q.push_back(exp_cmd(1'b0, (r == 0) ? 32'h500 : 32'h540));
        end
        k = 0;
        dc_addr     = 32'h300;
        ic_addr     = 32'h500;
        dc_req_read = 1'b1;
        ic_req      = 1'b1;
        n = 0;
        ic_seen = 0;
        while (ic_seen < 2 && n < 200) begin
            tick();
            n++;
            if (dc_done) begin
                k++;
                dc_addr = 32'h300 + 32'(16 * k);
            end
            if (ic_done) begin
                ic_seen++;
                ic_addr = 32'h540;
                if (ic_seen == 2) begin
                    ic_req      = 1'b0;
                    dc_req_read = 1'b0;
                end
            end
        end
        checks++;
        if (ic_seen != 2) begin
            failures++;
            $display("[TB] FAIL starve_timeout got ic_done=%0d want=2", ic_seen);
        end
        checks++;
        if (cmd_log.size() < first + 2 || (cmd_log[first+1].cyc - cmd_log[first].cyc) != 3) begin
            failures++;
            $display("[TB] FAIL starve_spacing got=%0d cycles want=3",
                     (cmd_log.size() < first + 2) ? -1 : cmd_log[first+1].cyc - cmd_log[first].cyc);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_cmd(c, ok);
            checks++;
            if (!ok || c.wr !== e.wr || c.addr !== e.addr) begin
                failures++;
                $display("[TB] FAIL starve_order got addr=%h want addr=%h", c.addr, e.addr);
            end
        end
    endtask

    task automatic test_flush();
        int   n;
        int   ic0;
        int   ack0;
        int   log0;
        bit   seen;
        bit   ok;
        exp_t e;
        cmd_t c;
        mem_latency = 3;
        ic0  = ic_pulses;
        ack0 = mem_acks;
        ic_addr = 32'h600;
        ic_req  = 1'b1;
        exp_q.push_back(exp_cmd(1'b0, 32'h600));
        n = 0;
        while (!mem_read && n < 10) begin
            tick();
            n++;
        end
        flush = 1'b1;
        tick();
        flush  = 1'b0;
        ic_req = 1'b0;
        n = 0;
        while (requested_data_to_mem && n < 20) begin
            tick();
            n++;
        end
        repeat (2) tick();
        checks++;
        if ((ic_pulses - ic0) != 0 || (mem_acks - ack0) != 1) begin
            failures++;
            $display("[TB] FAIL flush_inflight got ic_done=%0d acks=%0d want ic_done=0 acks=1",
                     ic_pulses - ic0, mem_acks - ack0);
        end
        log0 = cmd_log.size();
        flush   = 1'b1;
        ic_addr = 32'h640;
        ic_req  = 1'b1;
        repeat (3) tick();
        checks++;
        if (requested_data_to_mem !== 1'b0 || cmd_log.size() != log0) begin
            failures++;
            $display("[TB] FAIL flush_idle got busy=%b new_cmds=%0d want busy=0 new_cmds=0",
                     requested_data_to_mem, cmd_log.size() - log0);
        end
        ic_req = 1'b0;
        dc_addr = 32'h700;
        dc_req_read = 1'b1;
        exp_q.push_back(exp_cmd(1'b0, 32'h700));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (dc_done) seen = 1'b1;
        end
        dc_req_read = 1'b0;
        flush = 1'b0;
        checks++;
        if (!seen || dc_rdata !== line_of(32'h700)) begin
            failures++;
            $display("[TB] FAIL flush_dc seen=%b got=%h want=%h", seen, dc_rdata, line_of(32'h700));
        end
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_cmd(c, ok);
            checks++;
            if (!ok || c.wr !== e.wr || c.addr !== e.addr) begin
                failures++;
                $display("[TB] FAIL flush_cmd got addr=%h want addr=%h", c.addr, e.addr);
            end
        end
    endtask

    task automatic test_write_and_abort();
        int            n;
        int            dc0;
        bit            seen;
        logic [LB-1:0] wline;
        wline = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEED_F00D;
        mem_latency = 2;
        dc0 = dc_pulses;
        dc_addr      = 32'h80;
        dc_wdata     = wline;
        dc_req_read  = 1'b1;
        dc_req_write = 1'b1;
        n = 0;
        while (!(mem_read || mem_write) && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || address !== 32'h80 || writedata !== wline) begin
            failures++;
            $display("[TB] FAIL write_cmd got wr=%b rd=%b addr=%h data=%h want wr=1 rd=0 addr=80 data=%h",
                     mem_write, mem_read, address, writedata, wline);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (dc_done) seen = 1'b1;
        end
        dc_req_read  = 1'b0;
        dc_req_write = 1'b0;
        checks++;
        if (!seen || dc_rdata !== line_of(32'h700)) begin
            failures++;
            $display("[TB] FAIL write_hold seen=%b got=%h want=%h", seen, dc_rdata, line_of(32'h700));
        end
        repeat (2) tick();
        log_rd = cmd_log.size();
        mem_latency = 10;
        dc0 = dc_pulses;
        dc_addr = 32'h90;
        dc_req_write = 1'b1;
        n = 0;
        while (!mem_write && n < 10) begin
            tick();
            n++;
        end
        tick();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (requested_data_to_mem !== 1'b0 || mem_write !== 1'b0 || address !== 32'h0 || dc_rdata !== '0) begin
            failures++;
            $display("[TB] FAIL abort_state got busy=%b wr=%b addr=%h dc=%h want all 0",
                     requested_data_to_mem, mem_write, address, dc_rdata);
        end
        reset = 1'b0;
        dc_req_write = 1'b0;
        repeat (14) tick();
        checks++;
        if ((dc_pulses - dc0) != 0) begin
            failures++;
            $display("[TB] FAIL abort_no_done got=%0d want=0", dc_pulses - dc0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        ic_req       = 1'b1;
        ic_addr      = 32'h1000;
        dc_req_read  = 1'b1;
        dc_req_write = 1'b0;
        dc_addr      = 32'h2000;
        dc_wdata     = '1;
        $display("[TB] starting mem_arbiter bench");
        test_reset();
        test_lone_ic();
        test_simultaneous();
        test_starvation();
        test_flush();
        test_write_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
